pipeline_hazard_unit: RTL
=========================

Name: pipeline_hazard_unit

Overview:
- Parametrised hazard/forwarding controller for the in-order CPU pipeline (F, R, then DEPTH tracked stages X, M, W, ...).
- Keeps a registered write-tracker of in-flight destination registers, so it no longer needs to look at raw instruction words.
- Generates per-stage enables, an X-stage bubble request, and one-hot forwarding selects for both R-stage source operands.
- Adds capabilities the current controller lacks: branch flush, a memory-busy global freeze, and configurable depth and memory-result stage.

Parameters:
- REG_AW, 3, register address width (2**REG_AW architectural registers).
- DEPTH, 3, number of tracked stages after R (index 0 = X, DEPTH-1 = W); legal range 2..6.
- MEM_STAGE, 1, tracker index at which a memory-sourced result (LD/POP) first becomes forwardable; must be < DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- r_valid  in  1  R stage holds a real instruction.
- r_sr_use  in  1  R instruction reads SR.
- r_sr_addr  in  REG_AW  SR register address.
- r_tr_use  in  1  R instruction reads TR.
- r_tr_addr  in  REG_AW  TR register address.
- r_wr_en  in  1  R instruction writes a register.
- r_wr_addr  in  REG_AW  destination register.
- r_wr_mem  in  1  destination value comes from memory (LD/POP), not the ALU.
- flush  in  1  taken branch resolved in X; kill R.
- mem_busy  in  1  memory not ready; freeze whole pipeline.
- en  out  DEPTH+2  stage enables; bit0 = F, bit1 = R, bit2+i = tracked stage i.
- bubble_x  out  1  X latch loads a NOP this cycle.
- fwd_sr  out  DEPTH  one-hot source stage for SR; all-zero = register file.
- fwd_sr_mem  out  1  SR forward uses the memory-data path of the selected stage.
- fwd_tr  out  DEPTH  as fwd_sr, for TR.
- fwd_tr_mem  out  1  as fwd_sr_mem, for TR.

Behaviour:
- Tracker: DEPTH entries, each {valid, addr, mem}. Reset clears all valid bits; reset asserted mid-operation clears the tracker immediately.
- Match: for each source with use=1, find the youngest (lowest index) valid entry with addr == source address.
- Forwarding: fwd one-hot at that index and fwd_*_mem = entry.mem. No match, or use=0, gives fwd = 0 and mem = 0.
- Hazard: the matched entry has mem=1 and index < MEM_STAGE. stall = r_valid & hazard(SR or TR) & ~flush.
- Enables, combinational:
  - mem_busy=1: en = all 0, bubble_x = 0; tracker holds. mem_busy has priority over everything.
  - stall: en[0] = en[1] = 0, all other enables 1, bubble_x = 1.
  - flush (no mem_busy): en all 1, bubble_x = 1, overriding stall.
  - Otherwise: en all 1, bubble_x = 0.
- Tracker update on clk when mem_busy=0:
  - Entry i shifts to i+1; the last entry is discarded.
  - New entry 0 = {r_valid & r_wr_en & ~bubble_x, r_wr_addr, r_wr_mem}.
- Output values:
  - Reset / empty tracker with mem_busy=0: en all 1, bubble_x 0, fwd 0.
  - Inputs change while rst_n=0: outputs still reflect an empty tracker.
- Stall latency: a load immediately followed by a dependent instruction stalls MEM_STAGE cycles (1 at default). The dependent then forwards from index MEM_STAGE with mem=1.
- Same register in several entries: youngest wins. SR and TR may select the same stage.
- Combinational paths: from the inputs and tracker state only; no input-to-input loops.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined, adds outputs:
  - stall_cnt, 32-bit: counts cycles with stall=1 and mem_busy=0.
  - flush_cnt, 32-bit: counts cycles with flush=1 and mem_busy=0.
- Counter behaviour: both wrap at 2**32-1 -> 0 and clear on rst_n=0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0, then release with no traffic -> en = 5'b11111, bubble_x = 0, fwd_sr = fwd_tr = 0.
- ALU chain: ADD writes r2, then SUB reads SR=r2 next cycle -> fwd_sr = 3'b001, fwd_sr_mem = 0. Cycle after that -> fwd_sr = 3'b010.
- Load-use: LD writes r3 (mem=1), then ADD reads TR=r3 -> exactly 1 cycle with en = 5'b11100 and bubble_x = 1. Next cycle fwd_tr = 3'b010, fwd_tr_mem = 1.
- Flush over stall: load-use hazard present and flush=1 in the same cycle -> en = 5'b11111, bubble_x = 1, new tracker entry 0 invalid.
- Freeze: mem_busy=1 for 3 cycles mid-chain -> en = 0 throughout, fwd outputs unchanged. On release the tracker resumes with the same contents.
- Depth/priority: DEPTH=4, MEM_STAGE=2, r5 written in entries 1 and 3 -> fwd_sr = 4'b0010. A load at entry 1 read by the R instruction -> stall; once it reaches entry 2, forward with mem = 1.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: registered destination tracker, stage enables, bubble and forward selects.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cnt / flush_cnt performance counters.
module pipeline_hazard_unit #(
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 3,
  parameter int MEM_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_valid,
  input  logic              r_sr_use,
  input  logic [REG_AW-1:0] r_sr_addr,
  input  logic              r_tr_use,
  input  logic [REG_AW-1:0] r_tr_addr,
  input  logic              r_wr_en,
  input  logic [REG_AW-1:0] r_wr_addr,
  input  logic              r_wr_mem,
  input  logic              flush,
  input  logic              mem_busy,
  output logic [DEPTH+1:0]  en,
  output logic              bubble_x,
  output logic [DEPTH-1:0]  fwd_sr,
  output logic              fwd_sr_mem,
  output logic [DEPTH-1:0]  fwd_tr,
  output logic              fwd_tr_mem
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [DEPTH-1:0]  r_trk_valid;
  logic [DEPTH-1:0]  r_trk_mem;
  logic [REG_AW-1:0] r_trk_addr [DEPTH];

  logic [DEPTH-1:0]  w_sr_fwd;
  logic [DEPTH-1:0]  w_tr_fwd;
  logic              w_sr_mem;
  logic              w_tr_mem;
  logic              w_sr_haz;
  logic              w_tr_haz;
  logic              w_stall;
  logic [DEPTH+1:0]  w_en;
  logic              w_bubble;

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    w_sr_fwd = '0;
    w_sr_mem = 1'b0;
    w_sr_haz = 1'b0;
    w_tr_fwd = '0;
    w_tr_mem = 1'b0;
    w_tr_haz = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_sr_use && r_trk_valid[i] && (r_trk_addr[i] == r_sr_addr)) begin
        w_sr_fwd    = '0;
        w_sr_fwd[i] = 1'b1;
        w_sr_mem    = r_trk_mem[i];
        w_sr_haz    = r_trk_mem[i] && (i < MEM_STAGE);
      end
      if (r_tr_use && r_trk_valid[i] && (r_trk_addr[i] == r_tr_addr)) begin
        w_tr_fwd    = '0;
        w_tr_fwd[i] = 1'b1;
        w_tr_mem    = r_trk_mem[i];
        w_tr_haz    = r_trk_mem[i] && (i < MEM_STAGE);
      end
    end
  end

  assign w_stall = r_valid & (w_sr_haz | w_tr_haz) & ~flush;

  always_comb begin
    w_en     = '1;
    w_bubble = 1'b0;
    if (mem_busy) begin
      w_en     = '0;
      w_bubble = 1'b0;
    end else if (flush) begin
      w_bubble = 1'b1;
    end else if (w_stall) begin
      w_en[1:0] = 2'b00;
      w_bubble  = 1'b1;
    end
  end

  // A bubbled R instruction must not enter the tracker; it is either held or killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_valid <= '0;
      r_trk_mem   <= '0;
      for (int i = 0; i < DEPTH; i++) r_trk_addr[i] <= '0;
    end else if (!mem_busy) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_trk_valid[i] <= r_trk_valid[i-1];
        r_trk_mem[i]   <= r_trk_mem[i-1];
        r_trk_addr[i]  <= r_trk_addr[i-1];
      end
      r_trk_valid[0] <= r_valid & r_wr_en & ~w_bubble;
      r_trk_mem[0]   <= r_wr_mem;
      r_trk_addr[0]  <= r_wr_addr;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)   r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign en         = w_en;
  assign bubble_x   = w_bubble;
  assign fwd_sr     = w_sr_fwd;
  assign fwd_sr_mem = w_sr_mem;
  assign fwd_tr     = w_tr_fwd;
  assign fwd_tr_mem = w_tr_mem;

endmodule
